// File: rtl/systolic_feeder.sv
// Systolic feeder: holds 4x4 operand matrices A and B and streams them as
// diagonal-skewed wavefronts into a 4x4 systolic multiplier. After the feed
// it waits for the array to drain and then pulses done_o.
module systolic_feeder #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic              wr_sel_i,
    input  logic [3:0]        wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] left_o_0,
    output logic [DATA_W-1:0] left_o_4,
    output logic [DATA_W-1:0] left_o_8,
    output logic [DATA_W-1:0] left_o_12,
    output logic [DATA_W-1:0] up_o_0,
    output logic [DATA_W-1:0] up_o_1,
    output logic [DATA_W-1:0] up_o_2,
    output logic [DATA_W-1:0] up_o_3
);

    localparam int unsigned N        = 4;
    localparam int unsigned FeedLast = 2 * N - 2;
    // Counter is shared by FEED and DRAIN, so size it for the longer phase.
    localparam int unsigned CntMax   = (DRAIN_CYCLES > FeedLast) ? DRAIN_CYCLES : FeedLast;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] FeedLastC  = CntW'(FeedLast);
    localparam logic [CntW-1:0] DrainLastC = (DRAIN_CYCLES > 0) ? CntW'(DRAIN_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0] a_q [N][N];
    logic [DATA_W-1:0] b_q [N][N];

    logic [DATA_W-1:0] left_q [N];
    logic [DATA_W-1:0] left_d [N];
    logic [DATA_W-1:0] up_q [N];
    logic [DATA_W-1:0] up_d [N];
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              wr_ok;

    // Writes only land while idle, and never alongside an accepted start.
    assign wr_ok = wr_en_i && (state_q == StIdle) && !start_i;

    // Matrix storage; cleared by reset, otherwise persists across sequences.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (wr_sel_i) begin
                b_q[wr_addr_i[3:2]][wr_addr_i[1:0]] <= wr_data_i;
            end else begin
                a_q[wr_addr_i[3:2]][wr_addr_i[1:0]] <= wr_data_i;
            end
        end
    end

    // Sequencer state and phase counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: IDLE -> FEED (2N-1 wavefronts) -> DRAIN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFeed;
                    cnt_d   = '0;
                end
            end
            StFeed: begin
                if (cnt_q == FeedLastC) begin
                    cnt_d   = '0;
                    state_d = (DRAIN_CYCLES == 0) ? StDone : StDrain;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                if (cnt_q == DrainLastC) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-values are derived from the upcoming state/counter so that the
    // registered streams show wavefront k in the cycle after the k-th feed edge.
    // Row r carries A[r][j] at k = r + j; column c carries B[j][c] at k = j + c.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            left_d[i] = '0;
            up_d[i]   = '0;
        end
        busy_d = (state_d == StFeed) || (state_d == StDrain);
        done_d = (state_d == StDone);
        if (state_d == StFeed) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (cnt_d == CntW'(i + j)) begin
                        left_d[i] = a_q[i][j];
                        up_d[i]   = b_q[j][i];
                    end
                end
            end
        end
    end

    // Registered outputs; no combinational path from inputs to ports.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                left_q[i] <= '0;
                up_q[i]   <= '0;
            end
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                left_q[i] <= left_d[i];
                up_q[i]   <= up_d[i];
            end
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign left_o_0  = left_q[0];
    assign left_o_4  = left_q[1];
    assign left_o_8  = left_q[2];
    assign left_o_12 = left_q[3];
    assign up_o_0    = up_q[0];
    assign up_o_1    = up_q[1];
    assign up_o_2    = up_q[2];
    assign up_o_3    = up_q[3];

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder, including a small
// behavioural 4x4 systolic array fed from the DUT streams.
module tb_systolic_feeder;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] l0, l4, l8, l12, u0, u1, u2, u3;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ma [4][4];
    logic [31:0] mb [4][4];

    logic [31:0] lft [4];
    logic [31:0] upv [4];

    systolic_feeder #(
        .DATA_W       (32),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .wr_en_i   (wr_en),
        .wr_sel_i  (wr_sel),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .start_i   (start),
        .busy_o    (busy),
        .done_o    (done),
        .left_o_0  (l0),
        .left_o_4  (l4),
        .left_o_8  (l8),
        .left_o_12 (l12),
        .up_o_0    (u0),
        .up_o_1    (u1),
        .up_o_2    (u2),
        .up_o_3    (u3)
    );

    assign lft[0] = l0;
    assign lft[1] = l4;
    assign lft[2] = l8;
    assign lft[3] = l12;
    assign upv[0] = u0;
    assign upv[1] = u1;
    assign upv[2] = u2;
    assign upv[3] = u3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Behavioural systolic array: PE(i,j) accumulates left*up, passes right/down.
    logic        clr;
    logic [31:0] acc   [4][4];
    logic [31:0] acc_n [4][4];
    logic [31:0] ph    [4][5];
    logic [31:0] ph_n  [4][5];
    logic [31:0] pv    [5][4];
    logic [31:0] pv_n  [5][4];
    logic [31:0] lin, uin;

    always_comb begin
        acc_n = acc;
        ph_n  = ph;
        pv_n  = pv;
        lin   = '0;
        uin   = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                lin = (j == 0) ? lft[i] : ph[i][j];
                uin = (i == 0) ? upv[j] : pv[i][j];
                acc_n[i][j]  = acc[i][j] + lin * uin;
                ph_n[i][j+1] = lin;
                pv_n[i+1][j] = uin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) acc[i][j] <= '0;
                for (int j = 0; j < 5; j++) ph[i][j] <= '0;
            end
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) pv[i][j] <= '0;
            end
        end else begin
            acc <= acc_n;
            ph  <= ph_n;
            pv  <= pv_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_left(int r, int k);
        if (k - r >= 0 && k - r <= 3) return ma[r][k-r];
        return '0;
    endfunction

    function automatic logic [31:0] exp_up(int c, int k);
        if (k - c >= 0 && k - c <= 3) return mb[k-c][c];
        return '0;
    endfunction

    task automatic check_all(input string tag, input int k, input logic eb, input logic ed);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s left%0d k%0d", tag, i, k), lft[i], exp_left(i, k));
            check($sformatf("%s up%0d k%0d", tag, i, k), upv[i], exp_up(i, k));
        end
        check($sformatf("%s busy k%0d", tag, k), {31'd0, busy}, {31'd0, eb});
        check($sformatf("%s done k%0d", tag, k), {31'd0, done}, {31'd0, ed});
    endtask

    task automatic write_elem(input logic sel, input int r, input int c, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(r * 4 + c);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Starts a sequence from idle (at a negedge) and checks 14 cycles of output.
    task automatic run_seq(input string tag, input bit wr_with_start, input bit wr_in_feed,
                           input bit start_in_drain);
        start = 1'b1;
        clr   = 1'b1;
        if (wr_with_start) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_addr = 4'd4;
            wr_data = 32'd77;
        end
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            check_all(tag, (cyc <= 7) ? cyc - 1 : 99, cyc <= 10, cyc == 11);
            start = 1'b0;
            clr   = 1'b0;
            wr_en = 1'b0;
            if (cyc == 1 && wr_in_feed) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = 4'd0;
                wr_data = 32'd99;
            end
            if (cyc == 9 && start_in_drain) start = 1'b1;
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        clr     = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 99, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // A[r][c] = 4r+c+1, B[k][c] = c+1
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = 32'(4 * r + c + 1);
                mb[r][c] = 32'(c + 1);
                write_elem(1'b0, r, c, ma[r][c]);
                write_elem(1'b1, r, c, mb[r][c]);
            end
        end
        check_all("idle", 99, 1'b0, 1'b0);

        run_seq("base", 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("c0%0d", j), acc[0][j], 32'(10 * (j + 1)));
            check($sformatf("c3%0d", j), acc[3][j], 32'(58 * (j + 1)));
        end

        run_seq("wrfeed", 1'b0, 1'b1, 1'b0);
        run_seq("rerun", 1'b0, 1'b0, 1'b0);
        run_seq("drainstart", 1'b0, 1'b0, 1'b1);
        run_seq("wrstart", 1'b1, 1'b0, 1'b0);

        // Asynchronous reset while wavefront k=3 is on the streams.
        start = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_all("prereset", 3, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ma[r][c] = '0;
                mb[r][c] = '0;
            end
        end
        check_all("midreset", 99, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seq("zeros", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
